// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage scoreboard: per-register in-flight writer counters drive RAW / writer-overflow stalls.
// The FSM only measures stall duration so a stuck pipeline raises a sticky timeout flag.
//
// state    | meaning
// ST_RUN   | decode advanced (or idle) last cycle
// ST_STALL | decode held; stall_tmr_q counts down to the timeout terminal count

module hazard_scoreboard_ctrl #(
   parameter int NUM_REGS  = 32,
   parameter int ADDR_W    = 5,
   parameter int CNT_W     = 2,
   parameter int STALL_MAX = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [ADDR_W-1:0]   id_rs,
   input  logic [ADDR_W-1:0]   id_rt,
   input  logic                id_uses_rt,
   input  logic                id_reg_write,
   input  logic [ADDR_W-1:0]   id_wr_addr,
   input  logic                wb_reg_write,
   input  logic [ADDR_W-1:0]   wb_wr_addr,
   output logic                stall_flag_if,
   output logic                stall_flag_id,
   output logic                bubble_ex,
   output logic                issue,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                stall_timeout,
   output logic                sb_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam int               TMR_W    = $clog2(STALL_MAX + 1);
   localparam logic [TMR_W-1:0] TMR_IDLE = TMR_W'(STALL_MAX);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STALL_MAX - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [TMR_W-1:0]     stall_tmr_q, stall_tmr_d;
   logic                 timeout_q, timeout_d;
   logic                 underflow_q, underflow_d;
   logic [CNT_W-1:0]     cnt_q [NUM_REGS];
   logic [CNT_W-1:0]     cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_mask_q, busy_mask_d;
   logic [NUM_REGS-1:0]  inc_vec, dec_vec;
   logic                 rs_ready, rt_ready, wr_full;
   logic                 hazard_raw, hazard, issue_int;

   // A register with one pending writer that is writing back this cycle is readable (write-through RF).
   function automatic logic reg_ready(input logic [ADDR_W-1:0] r,
                                      input logic [CNT_W-1:0]  c,
                                      input logic              wb_we,
                                      input logic [ADDR_W-1:0] wb_a);
      return (r == '0) || (c == '0) || ((c == CNT_ONE) && wb_we && (wb_a == r));
   endfunction

   always_comb begin
      rs_ready   = reg_ready(id_rs, cnt_q[id_rs], wb_reg_write, wb_wr_addr);
      rt_ready   = reg_ready(id_rt, cnt_q[id_rt], wb_reg_write, wb_wr_addr);
      wr_full    = id_reg_write && (id_wr_addr != '0) && (cnt_q[id_wr_addr] == CNT_MAX)
                   && !(wb_reg_write && (wb_wr_addr == id_wr_addr));
      hazard_raw = id_valid && (!rs_ready || (id_uses_rt && !rt_ready) || wr_full);
      hazard     = !reset && hazard_raw;
      issue_int  = !reset && id_valid && !hazard_raw;
   end

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue_int && id_reg_write && (id_wr_addr != '0)) inc_vec[id_wr_addr] = 1'b1;
      if (wb_reg_write && (wb_wr_addr != '0))             dec_vec[wb_wr_addr] = 1'b1;
   end

   always_comb begin
      underflow_d = underflow_q;
      busy_mask_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_vec[i] && !dec_vec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (dec_vec[i] && !inc_vec[i]) begin
            if (cnt_q[i] == '0) underflow_d = 1'b1;
            else                cnt_d[i]    = cnt_q[i] - CNT_ONE;
         end
         busy_mask_d[i] = (cnt_d[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
         busy_mask_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
         busy_mask_q <= busy_mask_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         stall_tmr_q <= TMR_IDLE;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_tmr_q <= stall_tmr_d;
         timeout_q   <= timeout_d;
      end
   end

   // Timer holds remaining stall cycles before timeout; it parks at zero while the stall persists.
   always_comb begin
      state_d     = state_q;
      stall_tmr_d = stall_tmr_q;
      timeout_d   = timeout_q;
      case (state_q)
         ST_RUN: begin
            if (hazard) begin
               state_d     = ST_STALL;
               stall_tmr_d = TMR_LOAD;
            end
         end
         ST_STALL: begin
            if (hazard) begin
               if (stall_tmr_q != '0) stall_tmr_d = stall_tmr_q - TMR_ONE;
            end else begin
               state_d     = ST_RUN;
               stall_tmr_d = TMR_IDLE;
            end
         end
         default: begin
            state_d     = ST_RUN;
            stall_tmr_d = TMR_IDLE;
         end
      endcase
      if ((state_d == ST_STALL) && (stall_tmr_d == '0)) timeout_d = 1'b1;
   end

   always_comb begin
      stall_flag_if = hazard;
      stall_flag_id = hazard;
      bubble_ex     = hazard;
      issue         = issue_int;
   end

   assign busy_mask     = busy_mask_q;
   assign stall_timeout = timeout_q;
   assign sb_underflow  = underflow_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: a reference model pushes expected outputs per driven cycle,
// each scenario task pops and compares them, plus fixed-value checks at the key boundaries.

module tb_hazard_scoreboard_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_valid = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0, wb_reg_write = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_wr_addr = '0, wb_wr_addr = '0;
   logic        stall_flag_if, stall_flag_id, bubble_ex, issue, stall_timeout, sb_underflow;
   logic [31:0] busy_mask;

   hazard_scoreboard_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_wr_addr(id_wr_addr),
      .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr),
      .stall_flag_if(stall_flag_if), .stall_flag_id(stall_flag_id), .bubble_ex(bubble_ex),
      .issue(issue), .busy_mask(busy_mask), .stall_timeout(stall_timeout),
      .sb_underflow(sb_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic       rw;
      logic [4:0] wa;
      logic       wbw;
      logic [4:0] wba;
   } stim_t;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [3:0]  comb_q [$];
   logic [33:0] reg_q [$];
   int          m_cnt [32];
   bit          m_under, m_to, m_stall;
   int          m_scnt;

   function automatic stim_t st(logic rst, logic v, logic [4:0] rs, logic [4:0] rt, logic urt,
                                logic rw, logic [4:0] wa, logic wbw, logic [4:0] wba);
      stim_t s;
      s.rst = rst; s.v = v; s.rs = rs; s.rt = rt; s.urt = urt;
      s.rw = rw; s.wa = wa; s.wbw = wbw; s.wba = wba;
      return s;
   endfunction

   function automatic bit m_ready(logic [4:0] r, stim_t s);
      return (r == 0) || (m_cnt[r] == 0) || (m_cnt[r] == 1 && s.wbw && s.wba == r);
   endfunction

   // Drive one cycle of stimulus and push the model's expected outputs for it.
   task automatic drive(stim_t s);
      bit haz, iss, full, inc, dec;
      logic [31:0] busy;
      reset = s.rst; id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt;
      id_reg_write = s.rw; id_wr_addr = s.wa; wb_reg_write = s.wbw; wb_wr_addr = s.wba;
      haz = 0; iss = 0;
      if (s.rst) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_under = 0; m_to = 0; m_stall = 0; m_scnt = 0;
      end else begin
         full = s.rw && s.wa != 0 && m_cnt[s.wa] == 3 && !(s.wbw && s.wba == s.wa);
         haz  = s.v && (!m_ready(s.rs, s) || (s.urt && !m_ready(s.rt, s)) || full);
         iss  = s.v && !haz;
         for (int r = 1; r < 32; r++) begin
            inc = iss && s.rw && s.wa == r;
            dec = s.wbw && s.wba == r;
            if (inc && !dec) m_cnt[r]++;
            else if (dec && !inc) begin
               if (m_cnt[r] == 0) m_under = 1;
               else m_cnt[r]--;
            end
         end
         if (haz) begin
            m_scnt = m_stall ? ((m_scnt < 15) ? m_scnt + 1 : 15) : 1;
            m_stall = 1;
            if (m_scnt == 15) m_to = 1;
         end else begin
            m_stall = 0; m_scnt = 0;
         end
      end
      for (int i = 0; i < 32; i++) busy[i] = (m_cnt[i] != 0);
      comb_q.push_back({haz, haz, haz, iss});
      reg_q.push_back({busy, m_under, m_to});
   endtask

   task automatic test_reset();
      stim_t sq[$];
      logic [3:0] ec; logic [33:0] er;
      sq.push_back(st(1, 1, 5, 6, 1, 1, 5, 0, 0));
      sq.push_back(st(1, 1, 5, 6, 1, 1, 5, 1, 9));
      sq.push_back(st(0, 1, 1, 2, 1, 0, 0, 0, 0));
      sq.push_back(st(0, 0, 1, 2, 1, 0, 0, 0, 0));
      foreach (sq[i]) begin
         drive(sq[i]);
         @(negedge clk);
         ec = comb_q.pop_front(); n_checks++;
         if ({stall_flag_if, stall_flag_id, bubble_ex, issue} !== ec) begin
            n_fail++; $display("FAIL reset_comb step %0d: got %b want %b", i, {stall_flag_if, stall_flag_id, bubble_ex, issue}, ec);
         end
         if (i == 2) begin
            n_checks++;
            if (issue !== 1'b1 || stall_flag_if !== 1'b0) begin
               n_fail++; $display("FAIL reset_first_issue: got issue=%b stall=%b want 1/0", issue, stall_flag_if);
            end
         end
         @(posedge clk); #1;
         er = reg_q.pop_front(); n_checks++;
         if ({busy_mask, sb_underflow, stall_timeout} !== er) begin
            n_fail++; $display("FAIL reset_regs step %0d: got %h want %h", i, {busy_mask, sb_underflow, stall_timeout}, er);
         end
      end
   endtask

   task automatic test_raw();
      stim_t sq[$];
      logic [3:0] ec; logic [33:0] er;
      bit want_stall [6] = '{0, 1, 1, 1, 0, 0};
      sq.push_back(st(0, 1, 0, 0, 0, 1, 5, 0, 0));
      sq.push_back(st(0, 1, 5, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(0, 1, 5, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(0, 1, 5, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(0, 1, 5, 0, 0, 0, 0, 1, 5));
      sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (sq[i]) begin
         drive(sq[i]);
         @(negedge clk);
         ec = comb_q.pop_front(); n_checks++;
         if ({stall_flag_if, stall_flag_id, bubble_ex, issue} !== ec) begin
            n_fail++; $display("FAIL raw_comb step %0d: got %b want %b", i, {stall_flag_if, stall_flag_id, bubble_ex, issue}, ec);
         end
         n_checks++;
         if (bubble_ex !== want_stall[i]) begin
            n_fail++; $display("FAIL raw_stall_cycle %0d: got %b want %b", i, bubble_ex, want_stall[i]);
         end
         @(posedge clk); #1;
         er = reg_q.pop_front(); n_checks++;
         if ({busy_mask, sb_underflow, stall_timeout} !== er) begin
            n_fail++; $display("FAIL raw_regs step %0d: got %h want %h", i, {busy_mask, sb_underflow, stall_timeout}, er);
         end
      end
      n_checks++;
      if (busy_mask[5] !== 1'b0) begin
         n_fail++; $display("FAIL raw_busy5_cleared: got %b want 0", busy_mask[5]);
      end
   endtask

   task automatic test_r0();
      stim_t sq[$];
      logic [3:0] ec; logic [33:0] er;
      sq.push_back(st(0, 1, 0, 0, 0, 1, 0, 0, 0));
      sq.push_back(st(0, 1, 0, 0, 1, 0, 0, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));
      foreach (sq[i]) begin
         drive(sq[i]);
         @(negedge clk);
         ec = comb_q.pop_front(); n_checks++;
         if ({stall_flag_if, stall_flag_id, bubble_ex, issue} !== ec) begin
            n_fail++; $display("FAIL r0_comb step %0d: got %b want %b", i, {stall_flag_if, stall_flag_id, bubble_ex, issue}, ec);
         end
         @(posedge clk); #1;
         er = reg_q.pop_front(); n_checks++;
         if ({busy_mask, sb_underflow, stall_timeout} !== er) begin
            n_fail++; $display("FAIL r0_regs step %0d: got %h want %h", i, {busy_mask, sb_underflow, stall_timeout}, er);
         end
      end
   endtask

   task automatic test_full();
      stim_t sq[$];
      logic [3:0] ec; logic [33:0] er;
      repeat (3) sq.push_back(st(0, 1, 0, 0, 0, 1, 7, 0, 0));
      sq.push_back(st(0, 1, 0, 0, 0, 1, 7, 0, 0));
      sq.push_back(st(0, 1, 0, 0, 0, 1, 7, 1, 7));
      sq.push_back(st(0, 1, 7, 0, 0, 0, 0, 1, 7));
      sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 7));
      sq.push_back(st(0, 1, 0, 7, 1, 0, 0, 1, 7));
      sq.push_back(st(0, 1, 7, 0, 0, 0, 0, 0, 0));
      foreach (sq[i]) begin
         drive(sq[i]);
         @(negedge clk);
         ec = comb_q.pop_front(); n_checks++;
         if ({stall_flag_if, stall_flag_id, bubble_ex, issue} !== ec) begin
            n_fail++; $display("FAIL full_comb step %0d: got %b want %b", i, {stall_flag_if, stall_flag_id, bubble_ex, issue}, ec);
         end
         if (i == 3 || i == 4) begin
            n_checks++;
            if (issue !== (i == 4)) begin
               n_fail++; $display("FAIL full_fourth_writer step %0d: got issue=%b want %b", i, issue, i == 4);
            end
         end
         @(posedge clk); #1;
         er = reg_q.pop_front(); n_checks++;
         if ({busy_mask, sb_underflow, stall_timeout} !== er) begin
            n_fail++; $display("FAIL full_regs step %0d: got %h want %h", i, {busy_mask, sb_underflow, stall_timeout}, er);
         end
      end
   endtask

   task automatic test_underflow();
      stim_t sq[$];
      logic [3:0] ec; logic [33:0] er;
      bit want_uf [4] = '{1, 1, 1, 0};
      sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 9));
      sq.push_back(st(0, 1, 9, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (sq[i]) begin
         drive(sq[i]);
         @(negedge clk);
         ec = comb_q.pop_front(); n_checks++;
         if ({stall_flag_if, stall_flag_id, bubble_ex, issue} !== ec) begin
            n_fail++; $display("FAIL uf_comb step %0d: got %b want %b", i, {stall_flag_if, stall_flag_id, bubble_ex, issue}, ec);
         end
         @(posedge clk); #1;
         er = reg_q.pop_front(); n_checks++;
         if ({busy_mask, sb_underflow, stall_timeout} !== er) begin
            n_fail++; $display("FAIL uf_regs step %0d: got %h want %h", i, {busy_mask, sb_underflow, stall_timeout}, er);
         end
         n_checks++;
         if (sb_underflow !== want_uf[i] || busy_mask[9] !== 1'b0) begin
            n_fail++; $display("FAIL uf_sticky step %0d: got uf=%b busy9=%b want %b/0", i, sb_underflow, busy_mask[9], want_uf[i]);
         end
      end
   endtask

   task automatic test_timeout();
      stim_t sq[$];
      logic [3:0] ec; logic [33:0] er;
      sq.push_back(st(0, 1, 0, 0, 0, 1, 3, 0, 0));
      repeat (16) sq.push_back(st(0, 1, 3, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(1, 1, 3, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(0, 1, 3, 0, 0, 0, 0, 0, 0));
      foreach (sq[i]) begin
         drive(sq[i]);
         @(negedge clk);
         ec = comb_q.pop_front(); n_checks++;
         if ({stall_flag_if, stall_flag_id, bubble_ex, issue} !== ec) begin
            n_fail++; $display("FAIL to_comb step %0d: got %b want %b", i, {stall_flag_if, stall_flag_id, bubble_ex, issue}, ec);
         end
         @(posedge clk); #1;
         er = reg_q.pop_front(); n_checks++;
         if ({busy_mask, sb_underflow, stall_timeout} !== er) begin
            n_fail++; $display("FAIL to_regs step %0d: got %h want %h", i, {busy_mask, sb_underflow, stall_timeout}, er);
         end
         if (i >= 13 && i <= 17) begin
            n_checks++;
            if (stall_timeout !== (i == 15 || i == 16)) begin
               n_fail++; $display("FAIL to_edge after stall %0d: got %b want %b", i, stall_timeout, (i == 15 || i == 16));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t sq[$];
      logic [3:0] ec; logic [33:0] er;
      sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 80; k++)
         sq.push_back(st(0, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 5'($urandom_range(1, 3))));
      foreach (sq[i]) begin
         drive(sq[i]);
         @(negedge clk);
         ec = comb_q.pop_front(); n_checks++;
         if ({stall_flag_if, stall_flag_id, bubble_ex, issue} !== ec) begin
            n_fail++; $display("FAIL b2b_comb step %0d: got %b want %b", i, {stall_flag_if, stall_flag_id, bubble_ex, issue}, ec);
         end
         @(posedge clk); #1;
         er = reg_q.pop_front(); n_checks++;
         if ({busy_mask, sb_underflow, stall_timeout} !== er) begin
            n_fail++; $display("FAIL b2b_regs step %0d: got %h want %h", i, {busy_mask, sb_underflow, stall_timeout}, er);
         end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_raw();
      test_r0();
      test_full();
      test_underflow();
      test_timeout();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
